// File: rtl/bp_packet_arbiter_if.sv
// Handshake bundle for bp_packet_arbiter.
// Groups the requester side and the downstream BytePipe side.
interface bp_packet_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         bp_data;
  logic               bp_valid;
  logic               bp_ready;
  logic [N_REQ-1:0]   grant;
  logic               busy;

  modport master (
    output req_data, req_valid, bp_ready,
    input  req_ready, bp_data, bp_valid,
    input  grant, busy
  );

  modport slave (
    input  req_data, req_valid, bp_ready,
    output req_ready, bp_data, bp_valid,
    output grant, busy
  );
endinterface

// File: rtl/bp_packet_arbiter.sv
// Round-robin packet arbiter sharing one BytePipe between N_REQ sources.
// Grant is held for a whole length-prefixed packet, optional tag byte.
module bp_packet_arbiter #(
  parameter int N_REQ  = 2,
  parameter bit TAG_EN = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cg,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_valid,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [7:0]         o_bp_data,
  output logic               o_bp_valid,
  input  logic               i_bp_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TAG,
    S_LEN,
    S_PAY
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_g;
  logic [IW-1:0] r_last;
  logic [7:0]    r_rem;

  logic [IW-1:0]    w_sel;
  logic             w_found;
  logic             w_pass;
  logic             w_tag;
  logic [7:0]       w_gdata;
  logic             w_gvalid;
  logic [N_REQ-1:0] w_onehot;
  logic             w_xfer;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int k;
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(r_last) + i) % N_REQ;
      if (!w_found && i_req_valid[k]) begin
        w_found = 1'b1;
        w_sel   = IW'(k);
      end
    end
  end

  // Output steering from the registered state and grant.
  always_comb begin
    w_tag    = (r_state == S_TAG);
    w_pass   = (r_state == S_LEN) || (r_state == S_PAY);
    w_gdata  = i_req_data[{r_g, 3'b000} +: 8];
    w_gvalid = i_req_valid[r_g];
    w_onehot = N_REQ'(1) << r_g;
    o_busy   = (r_state != S_IDLE);
    o_grant  = o_busy ? w_onehot : '0;
    o_bp_valid = i_cg & (w_tag | (w_pass & w_gvalid));
    o_bp_data  = 8'h00;
    if (w_tag)
      o_bp_data = {{(8-IW){1'b0}}, r_g};
    else if (w_pass)
      o_bp_data = w_gdata;
    o_req_ready = (w_pass && i_cg && i_bp_ready) ? w_onehot : '0;
    w_xfer      = o_bp_valid & i_bp_ready;
  end

  // Packet FSM; everything frozen while the clock gate is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_last  <= IW'(N_REQ - 1);
      r_rem   <= '0;
    end else if (i_cg) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_g     <= w_sel;
            r_last  <= w_sel;
            r_state <= TAG_EN ? S_TAG : S_LEN;
          end
        end
        S_TAG: begin
          if (w_xfer) r_state <= S_LEN;
        end
        S_LEN: begin
          if (w_xfer) begin
            if (w_gdata == 8'h00) begin
              r_state <= S_IDLE;
            end else begin
              r_rem   <= w_gdata;
              r_state <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (w_xfer) begin
            r_rem <= r_rem - 8'd1;
            if (r_rem == 8'd1) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/bp_packet_arbiter.md
Name: bp_packet_arbiter

Overview:
- Shares one downstream BytePipe (e.g. the host-facing PTY/USB pipe) between N_REQ upstream BytePipe requesters (correlator, other bp* engines).
- Traffic is length-prefixed packets: first byte L, then L payload bytes.
- The arbiter grants one requester at a time, round-robin, and holds the grant for a whole packet. It can optionally prepend a source-tag byte so the host can demultiplex.

Parameters:
- N_REQ, 2, number of upstream requesters (2..8).
- TAG_EN, 1, 1: emit a tag byte (granted index, zero-extended) before each packet; 0: no tag.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_cg  input  1  clock-gate enable; 0 freezes all state and blocks all transfers.
- i_req_data  input  8*N_REQ  requester bytes; requester k uses bits [8k+7:8k].
- i_req_valid  input  N_REQ  per-requester valid.
- o_req_ready  output  N_REQ  per-requester ready.
- o_bp_data  output  8  downstream byte.
- o_bp_valid  output  1  downstream valid.
- i_bp_ready  input  1  downstream ready.
- o_grant  output  N_REQ  one-hot current grant; all zero in IDLE.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Transfer rule: a transfer occurs on a side when valid&ready is high at a rising i_clk edge with i_cg=1. When i_cg=0, o_bp_valid=0, o_req_ready=0 and no register changes.
- Reset (async, i_rst_n=0): state=IDLE, lastGrant=N_REQ-1, remaining=0. All outputs are 0 (o_grant=0, o_busy=0, o_bp_valid=0, o_bp_data=0, o_req_ready=0).
- Reset mid-packet: abandons the packet immediately. Downstream sees a truncated packet; recovery is the system's responsibility.
- FSM states: IDLE, TAG, LEN, PAYLOAD.
- IDLE:
  - o_req_ready=0, o_bp_valid=0.
  - With i_cg=1 and any i_req_valid high, select the first valid index searching from lastGrant+1 upward, modulo N_REQ.
  - Register that index in g and in lastGrant. Next state is TAG if TAG_EN, else LEN.
  - Arbitration costs exactly one cycle. No byte is consumed in IDLE.
- TAG:
  - o_bp_valid=i_cg, o_bp_data=g, o_req_ready=0.
  - On downstream transfer, go to LEN.
- LEN and PAYLOAD (combinational pass-through, zero latency):
  - o_bp_data=i_req_data[g], o_bp_valid=i_req_valid[g]&i_cg.
  - o_req_ready[g]=i_bp_ready&i_cg; all other ready bits are 0.
- LEN transfer with byte L:
  - If L=0, go to IDLE.
  - Otherwise remaining=L (8-bit) and go to PAYLOAD.
- PAYLOAD transfer:
  - If remaining=1, go to IDLE; otherwise remaining=remaining-1.
  - remaining never wraps: the PAYLOAD→IDLE exit happens at 1.
- Back-to-back packets:
  - A requester holding valid after its packet is re-arbitrated in IDLE. Other valid requesters win first (round-robin fairness).
  - Throughput ceiling per packet is L+1 (+1 with tag) transfer cycles, plus 1 IDLE cycle.
- Idle-valid stalls: valid may drop mid-packet; the grant is held indefinitely (no timeout).
- Non-granted requesters see ready=0 and must hold data stable.
- o_grant=onehot(g) in TAG/LEN/PAYLOAD, 0 in IDLE. o_busy=(state!=IDLE).
- i_bp_ready low stalls TAG/LEN/PAYLOAD with no state change. o_bp_data in TAG stays stable while stalled.
- Simultaneous requests at reset: requester 0 wins first, because lastGrant resets to N_REQ-1.

Test Plan:
- Single packet, TAG_EN=1, N_REQ=2: req1 sends 03 AA BB CC, downstream always ready.
  → output 01 03 AA BB CC on consecutive cycles after 1 IDLE cycle; o_grant=2'b10 throughout; return to IDLE.
- Round-robin: both requesters hold valid continuously with packets 01 11 (req0) and 01 22 (req1).
  → output order 00 01 11, 01 01 22, 00 01 11, …; o_grant alternates.
- Zero-length and stall: req0 sends 00; then a 02 55 66 packet with i_bp_ready toggling 1/0.
  → 00 00 emitted, then IDLE. Next packet bytes appear only on ready cycles; byte count exactly 2 payload bytes.
- Clock gate: i_cg=0 for 3 cycles mid-PAYLOAD with remaining=2.
  → o_bp_valid=0, o_req_ready=0, remaining stays 2; resumes correctly when i_cg=1.
- Async reset mid-PAYLOAD (remaining=5): assert i_rst_n=0 between clock edges.
  → o_busy, o_grant, o_bp_valid go 0 immediately. After release, simultaneous req0/req1 requests grant req0 first.
- TAG_EN=0, N_REQ=4, only req3 valid with FF followed by 255 bytes.
  → exactly 256 bytes forwarded, no tag; remaining reaches 1 then IDLE, no wrap.
